trapez_shaper_seq: RTL and testbench
====================================

// Module: trapez_shaper_seq
// PURPOSE
// - Sequencer for one trapezoidal shaper: gates ADC samples into the shaper, discards start-up transients, detects pulses above threshold.
// - Captures each pulse's peak over a fixed window and hands it downstream on a valid/ready handshake, then applies hold-off.
// - Sits between the ADC front end and the shaper data/result interfaces; the host drives start/stop/threshold.
// PARAMETERS
// - DATA_SIZE       16   ADC / shaper input sample width (signed), from settings_pkg
// - FULL_SIZE       32   shaper output width (signed), from settings_pkg
// - SETTLE_CYCLES   64   shaper output samples discarded after start (>=1)
// - PEAK_WINDOW     32   shaper output samples examined per pulse (>=1)
// - HOLDOFF_CYCLES  16   shaper output samples ignored after each report or reject (>=0)
// PORTS
// - clk                 in   1          system clock
// - reset               in   1          asynchronous, active-low reset
// - start               in   1          1-cycle pulse: leave IDLE
// - stop                in   1          1-cycle pulse: return to IDLE
// - threshold           in   FULL_SIZE  signed trigger level; sampled while ARMED
// - adc_data            in   DATA_SIZE  signed ADC sample
// - adc_valid           in   1          adc_data qualifier
// - shaper_input_data   out  DATA_SIZE  to shaper data interface, input_data
// - shaper_enable       out  1          to shaper data interface, enable
// - shaper_output_data  in   FULL_SIZE  from shaper result interface, output_data
// - shaper_output_valid in   1          from shaper result interface, output_data_valid
// - peak_data           out  FULL_SIZE  captured signed peak
// - peak_valid          out  1          peak_data valid; held until peak_ready
// - peak_ready          in   1          downstream accept
// - busy                out  1          state != IDLE
// - state_o             out  3          encoded FSM state (IDLE=0,SETTLE=1,ARMED=2,PEAK=3,REPORT=4,HOLDOFF=5)
// - pileup_cnt          out  16         pile-up rejects since start, saturating
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; shaper_input_data=0, shaper_enable=0, peak_data=0, peak_valid=0, busy=0, pileup_cnt=0, all counters 0.
// - Feed path, 1-cycle registered: shaper_input_data<=adc_data; shaper_enable<=adc_valid && state!=IDLE. No gating on other states.
// - Only cycles with shaper_output_valid=1 count as samples; all counters advance on samples only.
// - IDLE: on start -> SETTLE, cnt=0, pileup_cnt=0. start and stop in the same cycle: stop wins, stay IDLE.
// - SETTLE: discard samples; on the SETTLE_CYCLES-th sample -> ARMED.
// - ARMED: sample > threshold (signed, strict) -> PEAK with peak_reg=sample, cnt=1. If PEAK_WINDOW==1 -> REPORT directly.
// - PEAK: peak_reg=max(peak_reg,sample) per sample; on the PEAK_WINDOW-th sample (counting the trigger) -> REPORT, peak_data<=final max.
// - REPORT: peak_valid=1, peak_data stable. On peak_valid&&peak_ready -> HOLDOFF (or IDLE if stop is pending), peak_valid=0 next cycle. Samples ignored.
// - HOLDOFF: ignore HOLDOFF_CYCLES samples, then -> ARMED; if HOLDOFF_CYCLES==0, -> ARMED on the next clock.
// - stop: in any state except REPORT -> IDLE next edge, peak_valid stays 0. In REPORT, stop is latched, handshake completes, then -> IDLE.
// - start while not IDLE: ignored.
// - Counters sized $clog2(max param)+1; no wrap inside any state.
// - Mid-operation reset: immediate return to reset values; a pending peak is lost.
// CONFIGURATION
// - TRAPEZ_PILEUP_REJECT_EN defined: in PEAK, track above=(sample>threshold). A sample with above=1 after a sample with above=0 in the same window is a pile-up:
//   discard the peak, -> HOLDOFF, no report, pileup_cnt+=1 (saturates at 16'hFFFF).
// - Not defined: no pile-up check, every window reports; pileup_cnt tied to 0.
// TESTING
// - Reset then start, 64 valid samples of 0 -> state_o 1->2 exactly on the 64th sample; shaper_enable follows adc_valid with 1-cycle delay.
// - ARMED, threshold=100, window 32: samples 50,150,300,250,... -> peak_valid=1 with peak_data=300 after the 32nd window sample.
// - Hold peak_ready=0 for 10 cycles in REPORT while samples keep arriving -> peak_data constant, no second trigger; ready=1 -> HOLDOFF, ARMED after 16 samples.
// - stop during PEAK -> IDLE next edge, peak_valid never rises; start+stop same cycle in IDLE -> stays IDLE.
// - EN defined, window 200,50,180 (thr 100) -> no report, pileup_cnt=1, HOLDOFF; same stimulus without EN -> report peak_data=200.
// - Assert reset while in REPORT with peak_valid=1 -> all outputs 0 asynchronously, state_o=0.

Source files
------------

// File: rtl/trapez_shaper_seq.sv
// Sequencer for a trapezoidal shaper: feeds ADC samples, settles, triggers, captures peaks, hands them off.
// Optional pile-up rejection is compiled in when TRAPEZ_PILEUP_REJECT_EN is defined.
module trapez_shaper_seq #(
   parameter int DATA_SIZE      = 16,
   parameter int FULL_SIZE      = 32,
   parameter int SETTLE_CYCLES  = 64,
   parameter int PEAK_WINDOW    = 32,
   parameter int HOLDOFF_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic [FULL_SIZE-1:0] threshold,
   input  logic [DATA_SIZE-1:0] adc_data,
   input  logic                 adc_valid,
   output logic [DATA_SIZE-1:0] shaper_input_data,
   output logic                 shaper_enable,
   input  logic [FULL_SIZE-1:0] shaper_output_data,
   input  logic                 shaper_output_valid,
   output logic [FULL_SIZE-1:0] peak_data,
   output logic                 peak_valid,
   input  logic                 peak_ready,
   output logic                 busy,
   output logic [2:0]           state_o,
   output logic [15:0]          pileup_cnt
);

   localparam int MAXP = (SETTLE_CYCLES > PEAK_WINDOW)
                         ? ((SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES)
                         : ((PEAK_WINDOW > HOLDOFF_CYCLES) ? PEAK_WINDOW : HOLDOFF_CYCLES);
   localparam int CW = $clog2(MAXP) + 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] PEAK_LAST   = CW'(PEAK_WINDOW - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_ARMED   = 3'd2,
      S_PEAK    = 3'd3,
      S_REPORT  = 3'd4,
      S_HOLDOFF = 3'd5
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;
   logic signed [FULL_SIZE-1:0] r_peak, w_peak_nxt;
   logic [FULL_SIZE-1:0]  r_peak_data, w_peak_data_nxt;
   logic                  r_peak_valid, w_peak_valid_nxt;
   logic                  r_stop_pend, w_stop_pend_nxt;
   logic signed [FULL_SIZE-1:0] r_thr;
   logic [DATA_SIZE-1:0]  r_in_data;
   logic                  r_enable;
   logic signed [FULL_SIZE-1:0] w_sdata, w_max;
   logic                  w_above, w_pileup;
`ifdef TRAPEZ_PILEUP_REJECT_EN
   logic                  r_below_seen, w_below_nxt;
   logic [15:0]           r_pileup, w_pileup_nxt;
`endif

   assign w_sdata = signed'(shaper_output_data);
   assign w_max   = (w_sdata > r_peak) ? w_sdata : r_peak;
   // Threshold is captured while ARMED so a pulse is judged against one stable level.
   assign w_above = (w_sdata > r_thr);
`ifdef TRAPEZ_PILEUP_REJECT_EN
   assign w_pileup = w_above && r_below_seen;
`else
   assign w_pileup = 1'b0;
`endif

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_peak_nxt       = r_peak;
      w_peak_data_nxt  = r_peak_data;
      w_peak_valid_nxt = r_peak_valid;
      w_stop_pend_nxt  = r_stop_pend;
`ifdef TRAPEZ_PILEUP_REJECT_EN
      w_below_nxt      = r_below_seen;
      w_pileup_nxt     = r_pileup;
`endif
      case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               w_state_nxt = S_SETTLE;
               w_cnt_nxt   = '0;
`ifdef TRAPEZ_PILEUP_REJECT_EN
               w_pileup_nxt = '0;
`endif
            end
         end
         S_SETTLE: begin
            if (shaper_output_valid) begin
               if (r_cnt == SETTLE_LAST) begin
                  w_state_nxt = S_ARMED;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         S_ARMED: begin
            if (shaper_output_valid && (w_sdata > signed'(threshold))) begin
               w_peak_nxt = w_sdata;
               w_cnt_nxt  = CW'(1);
`ifdef TRAPEZ_PILEUP_REJECT_EN
               w_below_nxt = 1'b0;
`endif
               if (PEAK_WINDOW == 1) begin
                  w_state_nxt      = S_REPORT;
                  w_peak_data_nxt  = w_sdata;
                  w_peak_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_PEAK;
               end
            end
         end
         S_PEAK: begin
            if (shaper_output_valid) begin
               w_peak_nxt = w_max;
`ifdef TRAPEZ_PILEUP_REJECT_EN
               if (!w_above) w_below_nxt = 1'b1;
`endif
               if (w_pileup) begin
                  w_state_nxt = S_HOLDOFF;
                  w_cnt_nxt   = '0;
`ifdef TRAPEZ_PILEUP_REJECT_EN
                  if (r_pileup != 16'hFFFF) w_pileup_nxt = r_pileup + 16'd1;
`endif
               end else if (r_cnt == PEAK_LAST) begin
                  w_state_nxt      = S_REPORT;
                  w_peak_data_nxt  = w_max;
                  w_peak_valid_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         S_REPORT: begin
            if (stop) w_stop_pend_nxt = 1'b1;
            if (peak_ready) begin
               w_peak_valid_nxt = 1'b0;
               w_cnt_nxt        = '0;
               w_stop_pend_nxt  = 1'b0;
               w_state_nxt      = (r_stop_pend || stop) ? S_IDLE : S_HOLDOFF;
            end
         end
         S_HOLDOFF: begin
            if (HOLDOFF_CYCLES == 0) begin
               w_state_nxt = S_ARMED;
            end else if (shaper_output_valid) begin
               if (r_cnt == HOLD_LAST) begin
                  w_state_nxt = S_ARMED;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // stop overrides everything except an in-flight report, which completes first.
      if (stop && (r_state != S_IDLE) && (r_state != S_REPORT)) begin
         w_state_nxt      = S_IDLE;
         w_cnt_nxt        = '0;
         w_peak_valid_nxt = 1'b0;
         w_stop_pend_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_peak       <= '0;
         r_peak_data  <= '0;
         r_peak_valid <= 1'b0;
         r_stop_pend  <= 1'b0;
         r_thr        <= '0;
         r_in_data    <= '0;
         r_enable     <= 1'b0;
`ifdef TRAPEZ_PILEUP_REJECT_EN
         r_below_seen <= 1'b0;
         r_pileup     <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_peak       <= w_peak_nxt;
         r_peak_data  <= w_peak_data_nxt;
         r_peak_valid <= w_peak_valid_nxt;
         r_stop_pend  <= w_stop_pend_nxt;
         if (r_state == S_ARMED) r_thr <= signed'(threshold);
         r_in_data    <= adc_data;
         r_enable     <= adc_valid && (r_state != S_IDLE);
`ifdef TRAPEZ_PILEUP_REJECT_EN
         r_below_seen <= w_below_nxt;
         r_pileup     <= w_pileup_nxt;
`endif
      end
   end

   assign shaper_input_data = r_in_data;
   assign shaper_enable     = r_enable;
   assign peak_data         = r_peak_data;
   assign peak_valid        = r_peak_valid;
   assign busy              = (r_state != S_IDLE);
   assign state_o           = r_state;
`ifdef TRAPEZ_PILEUP_REJECT_EN
   assign pileup_cnt        = r_pileup;
`else
   assign pileup_cnt        = '0;
`endif

endmodule

// File: tb/tb_trapez_shaper_seq.sv
// Directed bench for trapez_shaper_seq: settle, trigger/peak, report back-pressure, holdoff, stop, pile-up, async reset.
module tb_trapez_shaper_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] threshold = 32'd100;
   logic [15:0] adc_data = '0;
   logic        adc_valid = 1'b0;
   logic [15:0] shaper_input_data;
   logic        shaper_enable;
   logic [31:0] shaper_output_data = '0;
   logic        shaper_output_valid = 1'b0;
   logic [31:0] peak_data;
   logic        peak_valid;
   logic        peak_ready = 1'b0;
   logic        busy;
   logic [2:0]  state_o;
   logic [15:0] pileup_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   trapez_shaper_seq dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .threshold(threshold),
      .adc_data(adc_data), .adc_valid(adc_valid),
      .shaper_input_data(shaper_input_data), .shaper_enable(shaper_enable),
      .shaper_output_data(shaper_output_data), .shaper_output_valid(shaper_output_valid),
      .peak_data(peak_data), .peak_valid(peak_valid), .peak_ready(peak_ready),
      .busy(busy), .state_o(state_o), .pileup_cnt(pileup_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp(input int v);
      shaper_output_valid = 1'b1;
      shaper_output_data  = v;
      tick();
      shaper_output_valid = 1'b0;
   endtask

   task automatic smp_n(input int v, input int n);
      for (int i = 0; i < n; i++) smp(v);
   endtask

   initial begin
      #3;
      check("rst_state", state_o, 0);
      check("rst_busy", busy, 0);
      check("rst_pvalid", peak_valid, 0);
      check("rst_pdata", peak_data, 0);
      check("rst_enable", shaper_enable, 0);
      check("rst_indata", shaper_input_data, 0);
      check("rst_pileup", pileup_cnt, 0);
      #9 reset = 1'b1;
      tick();

      // start and stop together in IDLE: stop wins
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      check("start_stop_idle", state_o, 0);

      // feed path: no enable while IDLE
      adc_valid = 1; adc_data = 16'd5; tick();
      check("feed_idle_en", shaper_enable, 0);
      check("feed_data", shaper_input_data, 5);
      start = 1; tick(); start = 0;
      check("start_settle", state_o, 1);
      adc_data = 16'd7; tick();
      check("feed_en_on", shaper_enable, 1);
      check("feed_data2", shaper_input_data, 7);
      adc_valid = 0; tick();
      check("feed_en_off", shaper_enable, 0);

      // settle: 64 samples, non-valid cycles in between do not count
      smp_n(0, 40); tick(); tick(); smp_n(0, 23);
      check("settle_63", state_o, 1);
      smp(0);
      check("settle_64", state_o, 2);

      // trigger and peak window
      smp(50);
      check("armed_below", state_o, 2);
      smp(150);
      check("trig_peak", state_o, 3);
      smp(300); smp(250); smp_n(10, 28);
      check("win_31_state", state_o, 3);
      check("win_31_pvalid", peak_valid, 0);
      smp(10);
      check("win_32_state", state_o, 4);
      check("win_32_pvalid", peak_valid, 1);
      check("win_32_pdata", peak_data, 300);

      // back-pressure in REPORT
      smp_n(1000, 10);
      check("bp_state", state_o, 4);
      check("bp_pdata", peak_data, 300);
      check("bp_pvalid", peak_valid, 1);
      peak_ready = 1; tick(); peak_ready = 0;
      check("hs_state", state_o, 5);
      check("hs_pvalid", peak_valid, 0);
      smp_n(500, 15);
      check("hold_15", state_o, 5);
      smp(500);
      check("hold_16", state_o, 2);

      // stop during PEAK
      smp(500);
      check("peak2", state_o, 3);
      stop = 1; tick(); stop = 0;
      check("stop_state", state_o, 0);
      check("stop_busy", busy, 0);
      check("stop_pvalid", peak_valid, 0);
      smp_n(600, 40);
      check("idle_no_pvalid", peak_valid, 0);

      // pile-up stimulus
      start = 1; tick(); start = 0;
      smp_n(0, 64);
      check("settle2", state_o, 2);
      smp(200); smp(50); smp(180);
`ifdef TRAPEZ_PILEUP_REJECT_EN
      check("pu_state", state_o, 5);
      check("pu_cnt", pileup_cnt, 1);
      check("pu_pvalid", peak_valid, 0);
      smp_n(0, 16);
      check("pu_rearm", state_o, 2);
      smp(120); smp_n(0, 31);
      check("pu_rep_state", state_o, 4);
      check("pu_rep_pdata", peak_data, 120);
`else
      check("nopu_state", state_o, 3);
      smp_n(0, 29);
      check("nopu_rep_state", state_o, 4);
      check("nopu_pdata", peak_data, 200);
      check("nopu_cnt", pileup_cnt, 0);
`endif
      check("rep_pvalid", peak_valid, 1);

      // async reset mid-REPORT, away from the clock edge
      #2 reset = 1'b0;
      #1;
      check("arst_state", state_o, 0);
      check("arst_pvalid", peak_valid, 0);
      check("arst_pdata", peak_data, 0);
      check("arst_busy", busy, 0);
      check("arst_pileup", pileup_cnt, 0);
      tick();
      check("arst_hold", state_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
